// File: rtl/sram_64k.sv
// sram_64k: single-port synchronous byte store, 2**ADDR_WIDTH words of
// DATA_WIDTH bits, with a registered read port.
//
// Ports:
//   clk      - system clock; writes commit and reads register on its rising edge
//   rst_n    - asynchronous active-low reset; clears data_out only, never the array
//   address  - word address shared by reads and writes
//   write    - 1 = write cycle, 0 = read cycle
//   data_in  - write data
//   data_out - registered read data, valid one cycle after the address is sampled
//
// Build option:
//   SRAM_64K_WRITE_THROUGH_EN - when defined, a write cycle also loads data_in
//   into data_out at the same edge. When undefined, data_out holds during writes.
module sram_64k #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Storage is deliberately left out of the reset domain so it can map onto
  // a RAM macro and so its contents survive a reset pulse.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [DATA_WIDTH-1:0] data_out_d;
  logic [DATA_WIDTH-1:0] data_out_q;

  // A write whose edge lands while reset is asserted is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && write) begin
      mem_q[address] <= data_in;
    end
  end

  always_comb begin
    data_out_d = data_out_q;
    if (!write) begin
      data_out_d = mem_q[address];
    end
`ifdef SRAM_64K_WRITE_THROUGH_EN
    else begin
      data_out_d = data_in;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_sram_64k.sv
module tb_sram_64k;

  logic        clk;
  logic        rst_n;
  logic [15:0] address;
  logic        write;
  logic [7:0]  data_in;
  logic [7:0]  data_out;

  int checks;
  int errors;

  // Reference model: sparse memory plus the expected output register.
  logic [7:0] ref_mem [int];
  logic [7:0] ref_out;
  bit         ref_known;

  logic [15:0] pool [16];

  sram_64k #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .address  (address),
    .write    (write),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] exp);
    checks++;
    assert (data_out === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, data_out, exp);
    end
  endtask

  // Drive one operation, let one rising edge take it, update the model,
  // then sample just after the edge.
  task automatic cycle(input logic wr, input logic [15:0] a, input logic [7:0] d,
                       input string tag);
    write   = wr;
    address = a;
    data_in = d;
    @(posedge clk);
    if (rst_n) begin
      if (wr) begin
        ref_mem[int'(a)] = d;
`ifdef SRAM_64K_WRITE_THROUGH_EN
        ref_out   = d;
        ref_known = 1'b1;
`endif
      end else if (ref_mem.exists(int'(a))) begin
        ref_out   = ref_mem[int'(a)];
        ref_known = 1'b1;
      end else begin
        ref_known = 1'b0;
      end
    end else begin
      ref_out   = 8'h00;
      ref_known = 1'b1;
    end
    #1;
    if (ref_known) check(tag, ref_out);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    write     = 1'b0;
    address   = '0;
    data_in   = '0;
    ref_out   = 8'h00;
    ref_known = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 8'h00);
    rst_n = 1'b1;

    // Basic write then read
    cycle(1'b1, 16'h0001, 8'hAA, "wr_0001");
    cycle(1'b0, 16'h0001, 8'h00, "rd_0001");
    check("rd_0001_const", 8'hAA);

    // Asynchronous reset mid-cycle forces zero before any edge
    rst_n = 1'b0;
    #1;
    ref_out = 8'h00;
    check("async_reset", 8'h00);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 16'h0001, 8'h00, "rd_after_reset");
    check("rd_after_reset_const", 8'hAA);

    // Boundaries and aliasing
    cycle(1'b1, 16'h0000, 8'h5A, "wr_0000");
    cycle(1'b1, 16'hFFFF, 8'hA5, "wr_ffff");
    cycle(1'b0, 16'h0000, 8'h00, "rd_0000");
    check("rd_0000_const", 8'h5A);
    cycle(1'b0, 16'hFFFF, 8'h00, "rd_ffff");
    check("rd_ffff_const", 8'hA5);
    cycle(1'b0, 16'h0001, 8'h00, "rd_0001_alias");
    check("rd_0001_alias_const", 8'hAA);

    // Overwrite; output during the writes is held or written-through
    cycle(1'b1, 16'h1234, 8'h11, "wr_1234_a");
`ifdef SRAM_64K_WRITE_THROUGH_EN
    check("wt_1234_a", 8'h11);
`else
    check("hold_1234_a", 8'hAA);
`endif
    cycle(1'b1, 16'h1234, 8'h22, "wr_1234_b");
`ifdef SRAM_64K_WRITE_THROUGH_EN
    check("wt_1234_b", 8'h22);
`else
    check("hold_1234_b", 8'hAA);
`endif
    cycle(1'b0, 16'h1234, 8'h00, "rd_1234");
    check("rd_1234_const", 8'h22);

    // Contents persist across a reset pulse
    cycle(1'b1, 16'h00FF, 8'h3C, "wr_00ff");
    rst_n = 1'b0;
    #1;
    ref_out = 8'h00;
    check("pulse_reset", 8'h00);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 16'h00FF, 8'h00, "rd_00ff");
    check("rd_00ff_const", 8'h3C);

    // Write coinciding with reset is discarded
    cycle(1'b1, 16'h0002, 8'h77, "wr_0002");
    rst_n = 1'b0;
    #1;
    ref_out = 8'h00;
    check("reset_before_wr", 8'h00);
    cycle(1'b1, 16'h0002, 8'hEE, "wr_0002_in_reset");
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 16'h0002, 8'h00, "rd_0002");
    check("rd_0002_const", 8'h77);

    // Randomized traffic over a pool of addresses, seeded with writes
    for (int i = 0; i < 16; i++) begin
      pool[i] = 16'($urandom);
      cycle(1'b1, pool[i], 8'($urandom), "rnd_seed_wr");
    end
    for (int i = 0; i < 300; i++) begin
      int idx;
      idx = int'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0)
        cycle(1'b1, pool[idx], 8'($urandom), "rnd_wr");
      else
        cycle(1'b0, pool[idx], 8'($urandom), "rnd_rd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_64k.md
Name: sram_64k

Overview:
- Single-port 64K x 8-bit static RAM: one shared address bus, one write-enable, separate data-in and data-out byte buses.
- Sits as a general-purpose byte store on the system clock.
- Writes are committed on the rising clock edge.
- Reads come out through a registered output port, one cycle after the address is sampled.

Parameters:
- ADDR_WIDTH, 16, address bus width; array depth is 2**ADDR_WIDTH (65536 at default).
- DATA_WIDTH, 8, word width in bits.

Ports:
- clk  input  1  system clock; all state changes occur on its rising edge, except reset.
- rst_n  input  1  asynchronous active-low reset.
- address  input  ADDR_WIDTH  word address for both read and write.
- write  input  1  1 = write cycle, 0 = read cycle.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  registered read data.

Behaviour:
- Storage: array of 2**ADDR_WIDTH words of DATA_WIDTH bits.
  - Contents are undefined after power-up.
  - Reset does NOT clear the array; contents persist across reset.
- Reset:
  - rst_n low forces data_out to 0 immediately, with no dependence on clk.
  - While rst_n is low, no writes are performed and data_out stays 0.
  - First active edge is the first rising clk edge with rst_n high.
- Write cycle (rising edge, rst_n=1, write=1):
  - mem[address] <= data_in.
  - data_out holds its previous value (see Optional Feature).
- Read cycle (rising edge, rst_n=1, write=0):
  - data_out <= mem[address].
  - Read latency is 1 cycle: data is valid after the edge that sampled the address and stays stable until the next read edge or reset.
- Read-after-write: a write to A at edge N followed by a read of A at edge N+1 returns the new data after edge N+1. There is no forwarding hazard, because the array is updated at edge N.
- Port semantics: single port, so exactly one operation per cycle. The write level alone selects the operation.
- Address range: full range 0x0000..0xFFFF valid. No wrap or out-of-range case exists; the address width matches the depth exactly.
- Reset mid-operation: a write whose edge coincides with rst_n low is discarded. Earlier completed writes are retained.
- Inputs are sampled only at rising clk edges; changes between edges have no effect.

Optional Feature:
- Macro: SRAM_64K_WRITE_THROUGH_EN.
- Defined: on a write cycle, data_out <= data_in at the same edge as the array write. A write is then visible on data_out one cycle later, with no separate read needed.
- Undefined (default): data_out holds its last value during write cycles.
- Array contents and read behaviour are identical in both builds.

Test Plan:
- Reset check: assert rst_n=0 mid-cycle -> data_out=0x00 immediately, before the next clk edge. Release, then idle read cycles -> no X on data_out after the first read of a written address.
- Basic write/read: write=1, address=0x0001, data_in=0xAA at one edge; then write=0, address=0x0001 -> data_out=0xAA after the following edge.
- Boundaries: write 0x5A@0x0000 and 0xA5@0xFFFF, then read both -> 0x5A, 0xA5. Also read 0x0001 -> still 0xAA (no aliasing).
- Overwrite and hold: write 0x11 then 0x22 to 0x1234, then read -> 0x22. In the default build data_out is unchanged during the two write cycles; with SRAM_64K_WRITE_THROUGH_EN it shows 0x11 then 0x22.
- Reset persistence: write 0x3C@0x00FF, pulse rst_n low (data_out -> 0x00), release, read 0x00FF -> 0x3C.
- Reset-coincident write: hold rst_n=0 across an edge with write=1, address=0x0002, data_in=0xEE after a prior 0x77@0x0002 -> a later read returns 0x77.
